// File: rtl/tug_war_pkg.sv
// Shared types for the tug-of-war playfield: FSM state and round-winner encodings.
package tug_war_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    LWIN  = 2'd1,
    RWIN  = 2'd2,
    MATCH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    W_NONE  = 2'b00,
    W_LEFT  = 2'b01,
    W_RIGHT = 2'b10
  } winner_e;

endpackage

// File: rtl/tug_input_cond.sv
// Key conditioner: 2-flop synchronizer followed by a rising-edge detector.
module tug_input_cond (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/tug_war_field.sv
// Tug-of-war playfield: position register, one-hot light bar, round scores, match-over.
// Define TUG_WAR_FIELD_EDGE_DET_EN to synchronize and edge-detect the L/R keys.
module tug_war_field
  import tug_war_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned SCORE_W    = 3,
  parameter int unsigned WIN_SCORE  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  next_round,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            round_winner,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic                  match_over
);

  localparam int unsigned PosW = $clog2(NUM_LIGHTS);
  localparam logic [PosW-1:0] Ctr = PosW'(NUM_LIGHTS / 2);
  localparam logic [PosW-1:0] PosMax = PosW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  logic lp, rp;

`ifdef TUG_WAR_FIELD_EDGE_DET_EN
  tug_input_cond u_cond_l (
    .clk   (clk),
    .reset (reset),
    .key   (L),
    .pulse (lp)
  );

  tug_input_cond u_cond_r (
    .clk   (clk),
    .reset (reset),
    .key   (R),
    .pulse (rp)
  );
`else
  assign lp = L;
  assign rp = R;
`endif

  state_e             state_q, state_d;
  winner_e            winner_q, winner_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;

  // Simultaneous presses cancel.
  logic move_l, move_r;
  assign move_l = lp & ~rp;
  assign move_r = rp & ~lp;

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    pos_d         = pos_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    unique case (state_q)
      PLAY: begin
        if (move_l) begin
          if (pos_q == PosMax) begin
            left_score_d = left_score_q + 1'b1;
            winner_d     = W_LEFT;
            state_d      = (left_score_d == WinScore) ? MATCH : LWIN;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (move_r) begin
          if (pos_q == '0) begin
            right_score_d = right_score_q + 1'b1;
            winner_d      = W_RIGHT;
            state_d       = (right_score_d == WinScore) ? MATCH : RWIN;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      LWIN, RWIN: begin
        if (next_round) begin
          state_d  = PLAY;
          pos_d    = Ctr;
          winner_d = W_NONE;
        end
      end
      MATCH: begin
        // Terminal until reset; scores and winner frozen.
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      winner_q      <= W_NONE;
      pos_q         <= Ctr;
      left_score_q  <= '0;
      right_score_q <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      pos_q         <= pos_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
    end
  end

  // Light bar is dark outside PLAY, so it can never be multi-hot.
  always_comb begin
    lights = '0;
    if (state_q == PLAY) begin
      lights[pos_q] = 1'b1;
    end
  end

  assign round_winner = winner_q;
  assign left_score   = left_score_q;
  assign right_score  = right_score_q;
  assign match_over   = (state_q == MATCH);

endmodule

// File: tb/tb_tug_war_field.sv
// Directed bench for tug_war_field with default parameters.
module tb_tug_war_field;

  localparam logic [8:0] Center = 9'b000010000;

`ifdef TUG_WAR_FIELD_EDGE_DET_EN
  localparam int Extra = 2;
`else
  localparam int Extra = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic       next_round = 1'b0;
  logic [8:0] lights;
  logic [1:0] round_winner;
  logic [2:0] left_score;
  logic [2:0] right_score;
  logic       match_over;

  int n_checks = 0;
  int n_errors = 0;

  tug_war_field dut (
    .clk          (clk),
    .reset        (reset),
    .L            (L),
    .R            (R),
    .next_round   (next_round),
    .lights       (lights),
    .round_winner (round_winner),
    .left_score   (left_score),
    .right_score  (right_score),
    .match_over   (match_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [8:0] e_lights, input logic [1:0] e_win,
                           input logic [2:0] e_ls, input logic [2:0] e_rs, input logic e_mo);
    check({tag, "/lights"}, 32'(lights), 32'(e_lights));
    check({tag, "/winner"}, 32'(round_winner), 32'(e_win));
    check({tag, "/left"}, 32'(left_score), 32'(e_ls));
    check({tag, "/right"}, 32'(right_score), 32'(e_rs));
    check({tag, "/match"}, 32'(match_over), 32'(e_mo));
  endtask

  task automatic press(input logic left, input logic right);
    L = left;
    R = right;
    tick();
    L = 1'b0;
    R = 1'b0;
    repeat (Extra) tick();
  endtask

  task automatic pulse_next();
    next_round = 1'b1;
    tick();
    next_round = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check_all("reset", Center, 2'b00, 3'd0, 3'd0, 1'b0);

    repeat (4) press(1'b1, 1'b0);
    check_all("left4", 9'b100000000, 2'b00, 3'd0, 3'd0, 1'b0);
    press(1'b1, 1'b0);
    check_all("lwin", 9'b000000000, 2'b01, 3'd1, 3'd0, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_all("lwin_ignore", 9'b000000000, 2'b01, 3'd1, 3'd0, 1'b0);
    pulse_next();
    check_all("next", Center, 2'b00, 3'd1, 3'd0, 1'b0);
    pulse_next();
    check_all("next_in_play", Center, 2'b00, 3'd1, 3'd0, 1'b0);

    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("right2/lights", 32'(lights), 32'(9'b000000100));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("back/lights", 32'(lights), 32'(Center));

    L = 1'b1;
    R = 1'b1;
    repeat (3) tick();
    L = 1'b0;
    R = 1'b0;
    repeat (Extra) tick();
    check_all("both", Center, 2'b00, 3'd1, 3'd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      repeat (4) press(1'b0, 1'b1);
      check("rround/edge", 32'(lights), 32'(9'b000000001));
      press(1'b0, 1'b1);
      check("rround/score", 32'(right_score), 32'(i + 1));
      if (i < 6) begin
        check("rround/winner", 32'(round_winner), 32'(2'b10));
        check("rround/match", 32'(match_over), 32'(1'b0));
        pulse_next();
      end else begin
        check_all("match", 9'b000000000, 2'b10, 3'd1, 3'd7, 1'b1);
      end
    end

    pulse_next();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    check_all("match_hold", 9'b000000000, 2'b10, 3'd1, 3'd7, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("reset_match", Center, 2'b00, 3'd0, 3'd0, 1'b0);

    repeat (5) press(1'b0, 1'b1);
    check("rwin1/score", 32'(right_score), 32'(3'd1));
    pulse_next();
    repeat (3) press(1'b1, 1'b0);
    check("pos7/lights", 32'(lights), 32'(9'b010000000));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("reset_mid", Center, 2'b00, 3'd0, 3'd0, 1'b0);

    repeat (5) press(1'b0, 1'b1);
    check("rwin2/winner", 32'(round_winner), 32'(2'b10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("reset_rwin", Center, 2'b00, 3'd0, 3'd0, 1'b0);

`ifdef TUG_WAR_FIELD_EDGE_DET_EN
    L = 1'b1;
    tick();
    check("hold_e1", 32'(lights), 32'(Center));
    tick();
    check("hold_e2", 32'(lights), 32'(Center));
    tick();
    check("hold_e3", 32'(lights), 32'(9'b000100000));
    repeat (7) tick();
    check("hold_e10", 32'(lights), 32'(9'b000100000));
    L = 1'b0;
    repeat (3) tick();
    check("hold_release", 32'(lights), 32'(9'b000100000));
`else
    L = 1'b1;
    repeat (3) tick();
    L = 1'b0;
    check("hold3", 32'(lights), 32'(9'b010000000));
    tick();
    check("hold_release", 32'(lights), 32'(9'b010000000));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
